// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one fixed-latency memory port between fetch and data
// Two requesters, one memory port: grants are held for LATENCY cycles and always separated by an IDLE cycle.
module mem_port_arbiter #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] addr1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic             mem_en,
   output logic [WIDTH-1:0] mem_addr,
   output logic             done0,
   output logic             done1
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [0:0] state;
   logic       owner;
   logic       last;
   logic [3:0] cnt;
   logic       next_owner;
   logic       owner_req;

   // On a tie the port not granted last time wins; otherwise the lone requester wins.
   always_comb begin
      next_owner = 1'b0;
      if (req0 && req1)
         next_owner = ~last;
      else
         next_owner = req1;
   end

   assign owner_req = owner ? req1 : req0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= 4'd0;
      end else if (state == IDLE) begin
         if (req0 || req1) begin
            state <= BUSY;
            owner <= next_owner;
            last  <= next_owner;
            cnt   <= CNT_INIT;
         end
      end else begin
         // A dropped request abandons the access; last stays so the other port is still favoured.
         if (!owner_req || cnt == 4'd0)
            state <= IDLE;
         else
            cnt <= cnt - 4'd1;
      end
   end

   assign sel      = owner;
   assign gnt0     = (state == BUSY) && !owner;
   assign gnt1     = (state == BUSY) && owner;
   assign mem_en   = (state == BUSY);
   assign mem_addr = sel ? addr1 : addr0;
   assign done0    = gnt0 && (cnt == 4'd0) && req0;
   assign done1    = gnt1 && (cnt == 4'd0) && req1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam logic [63:0] A0 = 64'h100;
   localparam logic [63:0] A1 = 64'h200;

   logic        clk = 1'b0;
   logic        reset, req0, req1;
   logic [63:0] addr0, addr1;
   logic        gnt0, gnt1, sel, mem_en, done0, done1;
   logic [63:0] mem_addr;

   logic        reset_b, req0_b, req1_b;
   logic [63:0] addr0_b, addr1_b;
   logic        gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b;
   logic [63:0] mem_addr_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(64), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .mem_en(mem_en), .mem_addr(mem_addr),
      .done0(done0), .done1(done1)
   );

   mem_port_arbiter #(.WIDTH(64), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset_b), .req0(req0_b), .req1(req1_b), .addr0(addr0_b), .addr1(addr1_b),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
      .done0(done0_b), .done1(done1_b)
   );

   // exp bits: {gnt0, gnt1, sel, mem_en, done0, done1}
   typedef struct packed {
      logic       rst;
      logic       r0;
      logic       r1;
      logic [5:0] exp;
   } vec_t;

   localparam int NV = 38;
   vec_t vecs [NV];

   task automatic check6(input string name, input logic [5:0] got, input logic [63:0] got_addr,
                         input logic [5:0] want, input logic [63:0] want_addr);
      total++;
      if (got !== want || got_addr !== want_addr) begin
         bad++;
         $display("FAIL %s: got outs=%b addr=%h, want outs=%b addr=%h", name, got, got_addr, want, want_addr);
      end
   endtask

   initial begin
      // reset and idle
      vecs[0]  = {1'b1, 1'b0, 1'b0, 6'b000000};
      vecs[1]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      vecs[2]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      vecs[3]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      vecs[4]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      vecs[5]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      // single port 0 access
      vecs[6]  = {1'b0, 1'b1, 1'b0, 6'b100100};
      vecs[7]  = {1'b0, 1'b1, 1'b0, 6'b100110};
      vecs[8]  = {1'b0, 1'b0, 1'b0, 6'b000000};
      // simultaneous after reset: port 0, idle gap, port 1
      vecs[9]  = {1'b1, 1'b0, 1'b0, 6'b000000};
      vecs[10] = {1'b0, 1'b1, 1'b1, 6'b100100};
      vecs[11] = {1'b0, 1'b1, 1'b1, 6'b100110};
      vecs[12] = {1'b0, 1'b0, 1'b1, 6'b000000};
      vecs[13] = {1'b0, 1'b0, 1'b1, 6'b011100};
      vecs[14] = {1'b0, 1'b0, 1'b1, 6'b011101};
      vecs[15] = {1'b0, 1'b0, 1'b0, 6'b001000};
      // alternation with both requesting
      vecs[16] = {1'b0, 1'b1, 1'b1, 6'b100100};
      vecs[17] = {1'b0, 1'b1, 1'b1, 6'b100110};
      vecs[18] = {1'b0, 1'b0, 1'b1, 6'b000000};
      vecs[19] = {1'b0, 1'b1, 1'b1, 6'b011100};
      vecs[20] = {1'b0, 1'b1, 1'b1, 6'b011101};
      vecs[21] = {1'b0, 1'b1, 1'b1, 6'b001000};
      vecs[22] = {1'b0, 1'b1, 1'b1, 6'b100100};
      vecs[23] = {1'b0, 1'b1, 1'b1, 6'b100110};
      vecs[24] = {1'b0, 1'b0, 1'b1, 6'b000000};
      // abandon in first busy cycle, pending port 1 served next
      vecs[25] = {1'b0, 1'b1, 1'b0, 6'b100100};
      vecs[26] = {1'b0, 1'b0, 1'b1, 6'b000000};
      vecs[27] = {1'b0, 1'b0, 1'b1, 6'b011100};
      vecs[28] = {1'b0, 1'b0, 1'b1, 6'b011101};
      vecs[29] = {1'b0, 1'b0, 1'b0, 6'b001000};
      // reset mid-access restores last=1
      vecs[30] = {1'b0, 1'b1, 1'b0, 6'b100100};
      vecs[31] = {1'b1, 1'b1, 1'b0, 6'b000000};
      vecs[32] = {1'b0, 1'b1, 1'b1, 6'b100100};
      vecs[33] = {1'b0, 1'b1, 1'b1, 6'b100110};
      vecs[34] = {1'b0, 1'b0, 1'b1, 6'b000000};
      vecs[35] = {1'b0, 1'b0, 1'b1, 6'b011100};
      vecs[36] = {1'b0, 1'b0, 1'b1, 6'b011101};
      vecs[37] = {1'b0, 1'b0, 1'b0, 6'b001000};

      addr0 = A0; addr1 = A1;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      reset_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;
      addr0_b = 64'hA0; addr1_b = 64'hB0;

      for (int i = 0; i < NV; i++) begin
         reset = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
         @(posedge clk); #1;
         check6($sformatf("vec%0d", i), {gnt0, gnt1, sel, mem_en, done0, done1}, mem_addr,
                vecs[i].exp, vecs[i].exp[3] ? A1 : A0);
         if (gnt0 && gnt1) begin
            total++; bad++;
            $display("FAIL excl vec%0d: got gnt0=1 gnt1=1, want at most one", i);
         end
      end

      // mem_addr follows the selected address combinationally while idle
      addr1 = 64'hDEAD_BEEF_0000_1234;
      #1;
      check6("idle_addr_follow", {gnt0, gnt1, sel, mem_en, done0, done1}, mem_addr,
             6'b001000, 64'hDEAD_BEEF_0000_1234);

      // LATENCY=1: single busy cycle carrying done
      @(posedge clk); #1;
      reset_b = 1'b0;
      check6("l1_reset", {gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b}, mem_addr_b,
             6'b000000, 64'hA0);
      req0_b = 1'b1;
      @(posedge clk); #1;
      check6("l1_busy", {gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b}, mem_addr_b,
             6'b100110, 64'hA0);
      req0_b = 1'b0; req1_b = 1'b1;
      @(posedge clk); #1;
      check6("l1_gap", {gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b}, mem_addr_b,
             6'b000000, 64'hA0);
      @(posedge clk); #1;
      check6("l1_port1", {gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b}, mem_addr_b,
             6'b011101, 64'hB0);
      req1_b = 1'b0;
      @(posedge clk); #1;
      check6("l1_idle", {gnt0_b, gnt1_b, sel_b, mem_en_b, done0_b, done1_b}, mem_addr_b,
             6'b001000, 64'hB0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: port 0 (instruction fetch) and port 1 (data access).
- Arbitrates round-robin, holds the grant for a fixed-latency access, and drives the select line of the shared 2:1 address mux.
- Sits between the fetch/memory pipeline stages and the single-ported memory model.

Parameters:
- WIDTH, 64, address width in bits.
- LATENCY, 2, memory access length in cycles; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until done0 or abandon.
- req1  input  1  port 1 request; held high until done1 or abandon.
- addr0  input  WIDTH  port 0 address; stable while req0 high.
- addr1  input  WIDTH  port 1 address; stable while req1 high.
- gnt0  output  1  port 0 owns the memory port.
- gnt1  output  1  port 1 owns the memory port.
- sel  output  1  shared mux select; 0 = port 0, 1 = port 1.
- mem_en  output  1  memory access active.
- mem_addr  output  WIDTH  address presented to memory (addr0 when sel=0, else addr1).
- done0  output  1  one-cycle pulse, port 0 access complete.
- done1  output  1  one-cycle pulse, port 1 access complete.

Behaviour:
- Clocking: single clock, clk. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk.
- Registered state:
  - state: IDLE or BUSY.
  - owner: 1 bit.
  - last: 1 bit, the last port granted.
  - cnt: 4 bits.
- Reset values: state=IDLE, owner=0, last=1 (so port 0 wins the first tie), cnt=0.
- Outputs after reset: gnt0=gnt1=0, sel=0, mem_en=0, done0=done1=0, mem_addr=addr0.
- Output decode (all combinational from registered state):
  - sel = owner.
  - gnt0 = BUSY & ~owner; gnt1 = BUSY & owner.
  - mem_en = BUSY.
  - mem_addr = sel ? addr1 : addr0, always, including in IDLE.
  - done0 = gnt0 & (cnt==0) & req0; done1 = gnt1 & (cnt==0) & req1.
- IDLE:
  - No request: stay IDLE.
  - Exactly one req: next owner = that port.
  - Both reqs: next owner = ~last.
  - On any grant: state<=BUSY, cnt<=LATENCY-1, last<=next owner.
- BUSY:
  - Owner's req low: abandon. state<=IDLE, no done pulse, last is not reverted.
  - Else if cnt==0: done pulses this cycle; state<=IDLE next edge.
  - Else: cnt<=cnt-1.
- Timing: req high at edge N produces gnt from cycle N+1. done is asserted in cycle N+LATENCY and gnt drops in cycle N+LATENCY+1.
- IDLE gap: at least one IDLE cycle between consecutive grants. Back-to-back service of the same port happens only when the other port is not requesting.
- Non-owner requests during BUSY are ignored and stay pending. The other port always gets the next grant if it requested (round-robin, no starvation).
- gnt0 and gnt1 are never high together. sel does not change during BUSY.
- Reset mid-access: the next edge forces IDLE, no done pulse, last=1.
- LATENCY=1: BUSY lasts exactly one cycle, with done asserted in that cycle.

Test Plan:
- Reset, then idle with req0=req1=0 for 5 cycles -> all outputs 0, mem_addr=addr0.
- req0=1, addr0=0x100, LATENCY=2, hold until done -> gnt0 and mem_en high for 2 cycles, done0 in the 2nd cycle, mem_addr=0x100, sel=0.
- req0 and req1 both raised in the same cycle after reset, each held until done -> port 0 served first, done0; one IDLE cycle; then gnt1 with sel=1, mem_addr=addr1, done1.
- req1 continuously high and req0 pulsed every grant -> grants alternate 1,0,1,0; sel never changes mid-access; gnt0 and gnt1 never both high.
- req0 dropped in the first BUSY cycle -> return to IDLE with no done0; a pending req1 is granted next.
- reset asserted during BUSY -> IDLE on the next edge, no done pulse; a subsequent simultaneous req0/req1 grants port 0 first.
